// File: rtl/code_lock_ctrl.sv
//------------------------------------------------------------------------------
// code_lock_ctrl
//
// Sequencing controller for an external 8-bit equality comparator.
//
// It streams one byte of the entered code (cmp_a) and one byte of the stored
// key (cmp_b) to the comparator each cycle. The per-byte equality result is
// folded over a fixed-length code, and the controller then reports either
// unlock or fail. After MAX_FAIL consecutive failures it enters a timed
// lockout, during which all input is ignored.
//
// A sequence whose first byte arrives with prog=1 programs a new key instead.
// The new key is collected in a shadow buffer and becomes the committed key
// only when the last byte arrives, so an aborted programming run leaves the
// old key intact.
//
// Parameters
//   LEN             bytes per code (>= 1)
//   MAX_FAIL        consecutive failed attempts that trigger lockout (>= 1)
//   LOCKOUT_CYCLES  lockout duration in clock cycles (>= 1)
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   din         entered byte
//   din_valid   din is presented this cycle
//   prog        first byte only: 1 = program key, 0 = check attempt
//   abort       drop the sequence in progress (PROG/CHECK only)
//   cmp_a       to comparator num1, equals din (combinational)
//   cmp_b       to comparator num2, equals key[idx] (combinational)
//   cmp_eq      from comparator o, same-cycle result
//   unlock      one-cycle pulse, registered
//   fail        one-cycle pulse, registered
//   locked_out  high while the lockout timer runs
//   busy        high while a sequence is in PROG or CHECK
//   fail_count  consecutive failures so far
//------------------------------------------------------------------------------
module code_lock_ctrl #(
  parameter int LEN            = 4,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    din,
  input  logic                          din_valid,
  input  logic                          prog,
  input  logic                          abort,
  output logic [7:0]                    cmp_a,
  output logic [7:0]                    cmp_b,
  input  logic                          cmp_eq,
  output logic                          unlock,
  output logic                          fail,
  output logic                          locked_out,
  output logic                          busy,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_count
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [IW-1:0] LAST_IDX   = IW'(LEN - 1);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAIL);
  localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PROG,
    CHECK,
    LOCKOUT
  } state_t;

  state_t        state;
  logic [7:0]    key    [LEN];
  logic [7:0]    shadow [LEN];
  logic [IW-1:0] idx;
  logic          mismatch;
  logic [LW-1:0] lock_cnt;

  logic          last_byte;
  logic          prog_mode;
  logic          in_seq;
  logic          mismatch_next;
  logic [FW-1:0] fail_next;

  // Comparator feed. idx is 0 in IDLE, so the first byte of a check is
  // compared against key[0] in the same cycle it is presented.
  assign cmp_a = din;
  assign cmp_b = key[idx];

  // With LEN=1 the very first byte (idx=0, still in IDLE) is also the last.
  assign last_byte = (idx == LAST_IDX);

  // prog is only meaningful on the first byte. Once a sequence has started,
  // the state alone decides between programming and checking.
  assign prog_mode = (state == PROG) || ((state == IDLE) && prog);

  assign in_seq = (state == PROG) || (state == CHECK);

  // The sticky flag starts fresh on the first byte; in CHECK it accumulates.
  // This is also the final verdict when it is evaluated on the last byte.
  assign mismatch_next = ((state == CHECK) && mismatch) || !cmp_eq;

  assign fail_next = fail_count + FW'(1);

  // NOTE: every register below is updated with non-blocking assignments in a
  // single clocked block, so all of them see pre-edge values of one another.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      mismatch   <= 1'b0;
      lock_cnt   <= '0;
      unlock     <= 1'b0;
      fail       <= 1'b0;
      locked_out <= 1'b0;
      busy       <= 1'b0;
      fail_count <= '0;
      // NOTE: key and shadow must come out of reset as a known all-zero key,
      // so these small register arrays are reset explicitly, unlike a RAM.
      for (int i = 0; i < LEN; i++) begin
        key[i]    <= 8'h00;
        shadow[i] <= 8'h00;
      end
    end else begin
      // Result strobes default low, so each one is high for exactly one
      // cycle after the edge that sets it.
      unlock <= 1'b0;
      fail   <= 1'b0;

      case (state)
        IDLE, PROG, CHECK: begin
          if (in_seq && abort) begin
            // abort wins over a simultaneous byte, including the last one.
            // key and fail_count are deliberately left untouched.
            state    <= IDLE;
            idx      <= '0;
            mismatch <= 1'b0;
            busy     <= 1'b0;
          end else if (din_valid) begin
            if (prog_mode) begin
              shadow[idx] <= din;
              if (last_byte) begin
                // Commit on the same edge. The last byte has not reached
                // shadow yet, so it is taken straight from din.
                for (int i = 0; i < LEN; i++) begin
                  key[i] <= (IW'(i) == idx) ? din : shadow[i];
                end
                state <= IDLE;
                idx   <= '0;
                busy  <= 1'b0;
              end else begin
                state <= PROG;
                idx   <= idx + IW'(1);
                busy  <= 1'b1;
              end
            end else begin
              if (last_byte) begin
                idx      <= '0;
                mismatch <= 1'b0;
                busy     <= 1'b0;
                if (mismatch_next) begin
                  fail       <= 1'b1;
                  fail_count <= fail_next;
                  if (fail_next == FAIL_LIMIT) begin
                    // locked_out rises together with the triggering fail.
                    // The counter then runs LOCK_LOAD..0, which keeps
                    // locked_out high for exactly LOCKOUT_CYCLES cycles.
                    state      <= LOCKOUT;
                    locked_out <= 1'b1;
                    lock_cnt   <= LOCK_LOAD;
                  end else begin
                    state <= IDLE;
                  end
                end else begin
                  unlock     <= 1'b1;
                  fail_count <= '0;
                  state      <= IDLE;
                end
              end else begin
                mismatch <= mismatch_next;
                idx      <= idx + IW'(1);
                state    <= CHECK;
                busy     <= 1'b1;
              end
            end
          end
        end

        LOCKOUT: begin
          // din_valid, prog and abort are all ignored here.
          if (lock_cnt == '0) begin
            state      <= IDLE;
            locked_out <= 1'b0;
            fail_count <= '0;
          end else begin
            lock_cnt <= lock_cnt - LW'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
